// File: rtl/sonar_buf_pkg.sv
// Shared definitions for the sonar line buffer: read-latency modes and writer FSM states.
package sonar_buf_pkg;

  localparam int RD_BYPASS = 0;
  localparam int RD_PIPE   = 1;

  typedef enum logic [0:0] {
    ST_FILL      = 1'b0,
    ST_WAIT_SWAP = 1'b1
  } wr_state_e;

endpackage

// File: rtl/scan_line_pingpong_if.sv
// Sample stream, random-read and line-handoff signals between sampler/renderer and the line buffer.
interface scan_line_pingpong_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              line_avail;
  logic [ADDR_W:0]   line_len;
  logic              rd_release;
  logic              overflow;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_valid, line_avail, line_len, overflow
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    output wr_ready, rd_data, rd_valid, line_avail, line_len, overflow
  );
endinterface

// File: rtl/sdp_ram.sv
// Inferred simple dual-port block RAM, one clock; read latency 1 (bypass) or 2 (pipelined).
// Output registers reset synchronously; rdata holds between requests.
module sdp_ram
  import sonar_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int READ_MODE = RD_BYPASS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_q;
  logic              rv_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= re;
      if (re) rd_q <= mem[raddr];
    end
  end

  generate
    if (READ_MODE == RD_PIPE) begin : g_pipe
      logic [DATA_W-1:0] out_q;
      logic              ov_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          out_q <= '0;
          ov_q  <= 1'b0;
        end else begin
          ov_q <= rv_q;
          if (rv_q) out_q <= rd_q;
        end
      end
      assign rdata  = out_q;
      assign rvalid = ov_q;
    end else begin : g_bypass
      assign rdata  = rd_q;
      assign rvalid = rv_q;
    end
  endgenerate
endmodule

// File: rtl/scan_line_pingpong.sv
// Ping-pong scan-line buffer: sampler fills one bank while renderer reads the last completed line.
// Reads 1 or 2 cycles; wr_ready drops while a finished line waits for the reader's release.
module scan_line_pingpong
  import sonar_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int READ_MODE = RD_BYPASS
) (
  input  logic                 clk,
  input  logic                 reset,
  scan_line_pingpong_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  wr_state_e         state_q, state_d;
  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   line_len_q, line_len_d;
  logic [ADDR_W:0]   pend_len_q, pend_len_d;
  logic              line_avail_q, line_avail_d;
  logic              overflow_q, overflow_d;

  logic              wr_ready;
  logic              accept;
  logic              complete;
  logic              swap;
  logic [ADDR_W:0]   swap_len;
  logic [ADDR_W:0]   cur_len;

  assign cur_len = {1'b0, wptr_q} + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      wbank_q      <= 1'b0;
      wptr_q       <= '0;
      line_len_q   <= '0;
      pend_len_q   <= '0;
      line_avail_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbank_q      <= wbank_d;
      wptr_q       <= wptr_d;
      line_len_q   <= line_len_d;
      pend_len_q   <= pend_len_d;
      line_avail_q <= line_avail_d;
      overflow_q   <= overflow_d;
    end
  end

  // A finished line parks in WAIT_SWAP only if the reader still holds the other bank.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:      if (complete && line_avail_q && !bus.rd_release) state_d = ST_WAIT_SWAP;
      ST_WAIT_SWAP: if (bus.rd_release) state_d = ST_FILL;
      default:      state_d = ST_FILL;
    endcase
  end

  always_comb begin
    wr_ready = (state_q == ST_FILL);
    accept   = bus.wr_valid && wr_ready;
    complete = accept && (bus.wr_last || (wptr_q == ADDR_W'(DEPTH - 1)));
  end

  always_comb begin
    wbank_d      = wbank_q;
    wptr_d       = wptr_q;
    line_len_d   = line_len_q;
    pend_len_d   = pend_len_q;
    line_avail_d = line_avail_q;
    overflow_d   = overflow_q | (bus.wr_valid && !wr_ready);
    swap         = 1'b0;
    swap_len     = cur_len;

    if (state_q == ST_FILL) begin
      if (accept) wptr_d = wptr_q + ADDR_W'(1);
      if (complete) begin
        wptr_d = '0;
        if (!line_avail_q || bus.rd_release) swap = 1'b1;
        else pend_len_d = cur_len;
      end
    end else if (bus.rd_release) begin
      swap     = 1'b1;
      swap_len = pend_len_q;
    end

    if (swap) begin
      wbank_d      = ~wbank_q;
      line_len_d   = swap_len;
      line_avail_d = 1'b1;
    end else if (bus.rd_release) begin
      line_avail_d = 1'b0;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.line_avail = line_avail_q;
  assign bus.line_len   = line_len_q;
  assign bus.overflow   = overflow_q;

  // Read side always addresses the bank not being written, using the pre-swap bank bit.
  sdp_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W + 1),
    .READ_MODE(READ_MODE)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr ({wbank_q, wptr_q}),
    .wdata (bus.wr_data),
    .re    (bus.rd_en),
    .raddr ({~wbank_q, bus.rd_addr}),
    .rdata (bus.rd_data),
    .rvalid(bus.rd_valid)
  );
endmodule

// File: tb/tb_scan_line_pingpong.sv
// Bench: two DEPTH=16 buffers (bypass and pipelined reads) share stimulus; a line-level model
// predicts flags, lengths and read data every cycle, plus hand-computed literal checks.
module tb_scan_line_pingpong;
  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;
  localparam int NC = 2048;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scan_line_pingpong_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  scan_line_pingpong_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  assign if1.wr_valid   = if0.wr_valid;
  assign if1.wr_data    = if0.wr_data;
  assign if1.wr_last    = if0.wr_last;
  assign if1.rd_en      = if0.rd_en;
  assign if1.rd_addr    = if0.rd_addr;
  assign if1.rd_release = if0.rd_release;

  scan_line_pingpong #(.DATA_W(DW), .DEPTH(DP), .READ_MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  scan_line_pingpong #(.DATA_W(DW), .DEPTH(DP), .READ_MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Line-level model: two banks of samples, the line in progress, a parked line, the reader's line.
  int mm [2*DP];
  bit mk [2*DP];
  int m_wb, m_fill, m_pend, m_avail, m_len, m_ovf;
  int cyc = 0;
  bit rv [NC];
  bit rk [NC];
  bit rs [NC];
  int rdat [NC];
  int last0 = 0, last1 = 0;
  bit known0 = 1'b0, known1 = 1'b0;
  bit cmp_en = 1'b0;

  task automatic model_step();
    int done_len;
    int idx;
    cyc++;
    rs[cyc] = reset; rv[cyc] = 1'b0; rk[cyc] = 1'b0; rdat[cyc] = 0;
    if (reset) begin
      m_wb = 0; m_fill = 0; m_pend = -1; m_avail = 0; m_len = 0; m_ovf = 0;
      return;
    end
    if (if0.rd_en) begin
      idx = (1 - m_wb) * DP + int'(if0.rd_addr);
      rv[cyc] = 1'b1; rk[cyc] = mk[idx]; rdat[cyc] = mm[idx];
    end
    done_len = 0;
    if (m_pend < 0 && if0.wr_valid) begin
      mm[m_wb*DP + m_fill] = int'(if0.wr_data);
      mk[m_wb*DP + m_fill] = 1'b1;
      m_fill++;
      if (if0.wr_last || m_fill == DP) begin
        done_len = m_fill;
        m_fill = 0;
      end
    end else if (if0.wr_valid) begin
      m_ovf = 1;
    end
    if (done_len > 0) begin
      if (!m_avail || if0.rd_release) begin
        m_wb = 1 - m_wb; m_len = done_len; m_avail = 1;
      end else begin
        m_pend = done_len;
      end
    end else if (m_pend >= 0 && if0.rd_release) begin
      m_wb = 1 - m_wb; m_len = m_pend; m_avail = 1; m_pend = -1;
    end else if (if0.rd_release) begin
      m_avail = 0;
    end
  endtask

  always @(negedge clk) begin : cmp_p
    int k;
    bit e0, e1;
    if (cmp_en) begin
      k = cyc;
      e0 = rv[k];
      e1 = (k > 0) ? (rv[k-1] && !rs[k]) : 1'b0;
      if (rs[k]) begin
        last0 = 0; known0 = 1'b1; last1 = 0; known1 = 1'b1;
      end
      if (e0) begin last0 = rdat[k];   known0 = rk[k];   end
      if (e1) begin last1 = rdat[k-1]; known1 = rk[k-1]; end
      chk("wr_ready0",   int'(if0.wr_ready),   int'(m_pend < 0));
      chk("wr_ready1",   int'(if1.wr_ready),   int'(m_pend < 0));
      chk("line_avail0", int'(if0.line_avail), m_avail);
      chk("line_avail1", int'(if1.line_avail), m_avail);
      chk("line_len0",   int'(if0.line_len),   m_len);
      chk("line_len1",   int'(if1.line_len),   m_len);
      chk("overflow0",   int'(if0.overflow),   m_ovf);
      chk("overflow1",   int'(if1.overflow),   m_ovf);
      chk("rd_valid0",   int'(if0.rd_valid),   int'(e0));
      chk("rd_valid1",   int'(if1.rd_valid),   int'(e1));
      if (known0) chk("rd_data0", int'(if0.rd_data), last0);
      if (known1) chk("rd_data1", int'(if1.rd_data), last1);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    if0.wr_valid = 1'b0; if0.wr_data = '0; if0.wr_last = 1'b0;
    if0.rd_en = 1'b0; if0.rd_addr = '0; if0.rd_release = 1'b0;
  endtask

  task automatic wr(input int d, input bit last, input bit rel);
    if0.wr_valid = 1'b1; if0.wr_data = DW'(d); if0.wr_last = last; if0.rd_release = rel;
    tick();
    idle();
  endtask

  task automatic rd(input int a);
    if0.rd_en = 1'b1; if0.rd_addr = AW'(a);
    tick();
    idle();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_ready"},   int'(if0.wr_ready),   1);
    chk({tag, "_line_avail"}, int'(if0.line_avail), 0);
    chk({tag, "_line_len"},   int'(if0.line_len),   0);
    chk({tag, "_overflow"},   int'(if0.overflow),   0);
    chk({tag, "_rd_valid"},   int'(if0.rd_valid),   0);
    chk({tag, "_rd_data"},    int'(if0.rd_data),    0);
    chk({tag, "_rd_data1"},   int'(if1.rd_data),    0);
  endtask

  initial begin
    int lens [4];
    lens = '{6, 9, 16, 4};
    for (int i = 0; i < 2*DP; i++) begin mm[i] = 0; mk[i] = 1'b0; end
    idle();
    reset = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    check_reset_vals("rst0");
    reset = 1'b0;

    // Short line of five samples, then read it back in both latency modes.
    for (int i = 0; i < 5; i++) wr(8'h10 + i, i == 4, 1'b0);
    chk("l1_avail", int'(if0.line_avail), 1);
    chk("l1_len", int'(if0.line_len), 5);
    chk("mdl_l1_len", m_len, 5);
    chk("mdl_bank0_idx3", mm[3], 8'h13);
    for (int a = 0; a < 5; a++) begin
      if0.rd_en = 1'b1; if0.rd_addr = AW'(a);
      tick();
      chk("l1_rd0", int'(if0.rd_data), 8'h10 + a);
      if (a > 0) chk("l1_rd1", int'(if1.rd_data), 8'h10 + a - 1);
    end
    idle();
    tick();
    chk("l1_rd1_last", int'(if1.rd_data), 8'h14);
    chk("l1_rv1_last", int'(if1.rd_valid), 1);
    chk("l1_rv0_idle", int'(if0.rd_valid), 0);

    // Release, redundant release, and an out-of-line read.
    if0.rd_release = 1'b1; tick(); idle();
    chk("rel_avail", int'(if0.line_avail), 0);
    if0.rd_release = 1'b1; tick(); idle();
    chk("rel2_avail", int'(if0.line_avail), 0);
    chk("rel2_len", int'(if0.line_len), 5);
    rd(10);
    chk("oob_rv0", int'(if0.rd_valid), 1);
    tick();
    chk("oob_rv0_off", int'(if0.rd_valid), 0);
    chk("oob_rv1", int'(if1.rd_valid), 1);

    // No wr_last: forced completion at 16, second line parks, extra samples overflow.
    for (int i = 0; i < 35; i++) begin
      wr(8'h40 + i, 1'b0, 1'b0);
      if (i == 15) chk("forced_len", int'(if0.line_len), 16);
      if (i == 31) chk("park_ready", int'(if0.wr_ready), 0);
    end
    chk("ovf_set", int'(if0.overflow), 1);
    chk("mdl_ovf", m_ovf, 1);
    if0.rd_release = 1'b1; tick(); idle();
    chk("unpark_ready", int'(if0.wr_ready), 1);
    chk("unpark_avail", int'(if0.line_avail), 1);
    chk("unpark_len", int'(if0.line_len), 16);
    rd(0);
    chk("l2_rd0", int'(if0.rd_data), 8'h50);
    chk("ovf_sticky", int'(if0.overflow), 1);

    // Completion coinciding with release swaps immediately.
    wr(8'h70, 1'b0, 1'b0);
    wr(8'h71, 1'b0, 1'b0);
    wr(8'h72, 1'b1, 1'b1);
    chk("imm_ready", int'(if0.wr_ready), 1);
    chk("imm_avail", int'(if0.line_avail), 1);
    chk("imm_len", int'(if0.line_len), 3);
    rd(2);
    chk("imm_rd", int'(if0.rd_data), 8'h72);

    // Reset in mid-line, then a fresh line lands at index 0 of bank 0.
    for (int i = 0; i < 3; i++) wr(8'h80 + i, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_vals("rst1");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'h90 + i, i == 3, 1'b0);
    chk("fresh_len", int'(if0.line_len), 4);
    rd(0);
    chk("fresh_rd0", int'(if0.rd_data), 8'h90);
    rd(3);
    chk("fresh_rd3", int'(if0.rd_data), 8'h93);

    // Continuous reads while four lines stream through with immediate swaps.
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < lens[l]; i++) begin
        if0.rd_en = 1'b1; if0.rd_addr = AW'((i*5 + l*3 + 1) % DP);
        if0.wr_valid = 1'b1; if0.wr_data = DW'(((l + 10) << 4) | i);
        if0.wr_last = (i == lens[l] - 1); if0.rd_release = (i == lens[l] - 1);
        tick();
      end
      idle();
      chk("stream_len", int'(if0.line_len), lens[l]);
      rd(0);
      chk("stream_rd0", int'(if0.rd_data), (l + 10) << 4);
    end
    tick();
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
